// File: rtl/ex_muldiv_unit.sv
// Purpose : RV32M multiply/divide unit in the EX stage (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency : multiply done in cycle 2, divide done in cycle 33, divide special cases done in cycle 1.
// Backpres: busy_o stalls ID/EX and earlier stages while working; flush_i aborts with no done_o.
//
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   start_i, flush_i    - M instruction present in EX / pipeline flush (flush wins over start)
//   funct3_i            - operation select, sampled in IDLE only
//   op1_i, op2_i        - forwarded rs1/rs2 operands, sampled in IDLE only
//   busy_o              - combinational stall request
//   done_o              - one-cycle completion pulse
//   result_o            - registered result, held until the next completion
module ex_muldiv_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;

   // Latched operation context
   logic [1:0]  f3_q;        // funct3[1:0]; funct3[2] is implied by the state
   logic [31:0] opa_q;       // MUL: raw op1; DIV: dividend magnitude, shifted into quotient
   logic [31:0] opb_q;       // MUL: raw op2; DIV: divisor magnitude
   logic [31:0] rem_q;       // partial remainder
   logic [4:0]  cnt_q;       // divide iteration counter, 31 down to 0
   logic        neg_quo_q;   // quotient must be negated
   logic        neg_rem_q;   // remainder must be negated

   // ------------------------------------------------------------------
   // Decode of live inputs, only meaningful while in IDLE
   // ------------------------------------------------------------------
   logic        in_signed_div;
   logic        in_op1_neg;
   logic        in_op2_neg;
   logic [31:0] in_mag1;
   logic [31:0] in_mag2;
   logic        div_by_zero;
   logic        div_ovf;
   logic        div_special;
   logic [31:0] special_res;

   always_comb begin
      in_signed_div = ~funct3_i[0];
      in_op1_neg    = in_signed_div & op1_i[31];
      in_op2_neg    = in_signed_div & op2_i[31];
      in_mag1       = in_op1_neg ? (32'd0 - op1_i) : op1_i;
      in_mag2       = in_op2_neg ? (32'd0 - op2_i) : op2_i;
      div_by_zero   = (op2_i == 32'd0);
      div_ovf       = in_signed_div & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);
      div_special   = funct3_i[2] & (div_by_zero | div_ovf);
      // funct3[1] selects remainder over quotient
      if (div_by_zero) begin
         special_res = funct3_i[1] ? op1_i : 32'hFFFF_FFFF;
      end else begin
         special_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // ------------------------------------------------------------------
   // Multiply: 33x33 signed product. The product magnitude fits in 64 bits,
   // so a 64-bit modular multiply of the sign-extended operands is exact.
   // ------------------------------------------------------------------
   logic        mul_a_sgn;
   logic        mul_b_sgn;
   logic [63:0] mul_a64;
   logic [63:0] mul_b64;
   logic [63:0] prod;
   logic [31:0] mul_res;

   always_comb begin
      mul_a_sgn = (f3_q != 2'b11);   // MUL, MULH, MULHSU treat op1 as signed
      mul_b_sgn = ~f3_q[1];          // MUL, MULH treat op2 as signed
      mul_a64   = {{32{mul_a_sgn & opa_q[31]}}, opa_q};
      mul_b64   = {{32{mul_b_sgn & opb_q[31]}}, opb_q};
      prod      = mul_a64 * mul_b64;
      mul_res   = (f3_q == 2'b00) ? prod[31:0] : prod[63:32];
   end

   // ------------------------------------------------------------------
   // Divide: one restoring step per cycle on magnitudes
   // ------------------------------------------------------------------
   logic [32:0] div_shift;
   logic        div_fits;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic [31:0] quo_fin;
   logic [31:0] rem_fin;

   always_comb begin
      div_shift = {rem_q, opa_q[31]};
      div_fits  = (div_shift >= {1'b0, opb_q});
      // When it fits the difference is below the divisor, so 32 bits are exact
      rem_nxt   = div_fits ? (div_shift[31:0] - opb_q) : div_shift[31:0];
      quo_nxt   = {opa_q[30:0], div_fits};
      quo_fin   = neg_quo_q ? (32'd0 - quo_nxt) : quo_nxt;
      rem_fin   = neg_rem_q ? (32'd0 - rem_nxt) : rem_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (!funct3_i[2]) begin
                     state_d = S_MUL;
                  end else if (div_special) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DIV;
                  end
               end
            end
            S_MUL:   state_d = S_DONE;
            S_DIV:   state_d = (cnt_q == 5'd0) ? S_DONE : S_DIV;
            S_DONE:  state_d = S_IDLE;   // start_i deliberately ignored here
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM: outputs. busy_o is combinational so ID/EX holds from the first EX cycle.
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      if (!flush_i) begin
         case (state_q)
            S_IDLE:  busy_o = start_i;
            S_MUL:   busy_o = 1'b1;
            S_DIV:   busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: busy_o = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         f3_q      <= 2'b00;
         opa_q     <= 32'd0;
         opb_q     <= 32'd0;
         rem_q     <= 32'd0;
         cnt_q     <= 5'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_o  <= 32'd0;
      end else if (!flush_i) begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  f3_q      <= funct3_i[1:0];
                  rem_q     <= 32'd0;
                  cnt_q     <= 5'd31;
                  neg_quo_q <= in_op1_neg ^ in_op2_neg;
                  neg_rem_q <= in_op1_neg;
                  if (funct3_i[2]) begin
                     opa_q <= in_mag1;
                     opb_q <= in_mag2;
                  end else begin
                     opa_q <= op1_i;
                     opb_q <= op2_i;
                  end
                  if (div_special) begin
                     result_o <= special_res;
                  end
               end
            end
            S_MUL: begin
               result_o <= mul_res;
            end
            S_DIV: begin
               opa_q <= quo_nxt;
               rem_q <= rem_nxt;
               if (cnt_q == 5'd0) begin
                  result_o <= f3_q[1] ? rem_fin : quo_fin;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Purpose : self-checking bench for ex_muldiv_unit with a result/latency scoreboard.
// Latency : expectations carry the completion cycle relative to the issue cycle.
// Backpres: busy_o is checked cycle by cycle while an operation is in flight.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  f3 = 3'd0;
   logic [31:0] op1 = 32'd0;
   logic [31:0] op2 = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   ex_muldiv_unit dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .flush_i  (flush),
      .funct3_i (f3),
      .op1_i    (op1),
      .op2_i    (op2),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res = 32'd0;

   typedef struct {
      logic [31:0] res;
      int          start;
      int          lat;
      string       name;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every done_o pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done_o high at cycle %0d with no operation pending", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_latency"}, cyc - e.start, e.lat);
         end
      end
   end

   // Issue one operation, hold start_i through DONE (as a stalled pipeline would),
   // and scramble the operands after the issue cycle to show they are not re-sampled.
   task automatic run_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int lat);
      exp_t e;
      @(posedge clk); #1;
      flush = 1'b0;
      start = 1'b1;
      f3    = fn;
      op1   = a;
      op2   = b;
      e.res = exp_r; e.start = cyc; e.lat = lat; e.name = name;
      sb.push_back(e);
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk);
         check({name, "_busy"}, {31'd0, busy}, (i < lat) ? 32'd1 : 32'd0);
         if (i < lat) begin
            @(posedge clk); #1;
            op1 = ~a;
            op2 = b + 32'd1;
            f3  = ~fn;
         end
      end
      last_res = exp_r;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy",   {31'd0, busy}, 32'd0);
      check("reset_done",   {31'd0, done}, 32'd0);
      check("reset_result", result,        32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Multiply family
      run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
      run_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
      run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      run_op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2);

      // Divide family
      run_op("div",    3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33);
      run_op("rem",    3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33);
      run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
      run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33);

      // Special cases
      run_op("divu_by0", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op("rem_by0",  3'b110, 32'd5,         32'd0,         32'd5,         1);

      // Flush in cycle 10 of a divide, then a multiply issued in cycle 11
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'b100; op1 = 32'hFFFF_FFEC; op2 = 32'd3;
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_busy",   {31'd0, busy}, 32'd0);
      check("flush_done",   {31'd0, done}, 32'd0);
      check("flush_result", result,        last_res);
      run_op("mulhu_after_flush", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);

      // Reset in cycle 5 of a divide
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'b101; op1 = 32'd100; op2 = 32'd7;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midreset_busy",   {31'd0, busy}, 32'd0);
      check("midreset_done",   {31'd0, done}, 32'd0);
      check("midreset_result", result,        32'd0);
      run_op("mul_after_reset", 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 2);

      // Drain: no stray completions, nothing left pending
      repeat (40) @(posedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
